// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: buffers write/read/read-compare commands and
// returns one response per command with compare-mismatch and timeout flags.
module axi_lite_cmd_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            rsp_resp,
    output logic [1:0]            rsp_flags,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [15:0]           err_count
);
    // state | meaning
    // IDLE  | waiting for a buffered command
    // WADDR | AW and W channels offered, each retires on its own handshake
    // WRESP | waiting for B
    // RADDR | AR offered
    // RDATA | waiting for R
    // RSP   | response held until rsp_ready
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENT_W  = 2 + ADDR_W + DATA_W + STRB_W;
    localparam int TO_W   = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;
    state_t state, state_nxt;

    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              full, empty, push, pop;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [STRB_W-1:0] head_strb;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic              aw_done, w_done;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              mismatch_q, to_flag;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] cmp_mask;
    logic              busy, rsp_hs;

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign cmd_ready = !full && !axi_areset;
    assign push  = cmd_valid && cmd_ready;
    assign pop   = (state == IDLE) && !empty;
    assign {head_op, head_addr, head_data, head_strb} = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge axi_aclk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_op, cmd_addr, cmd_data, cmd_strb};
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = (head_op == 2'b00) ? WADDR : RADDR;
            WADDR: if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WRESP;
            WRESP: if (m_axi_bvalid) state_nxt = RSP;
            RADDR: if (m_axi_arready) state_nxt = RDATA;
            RDATA: if (m_axi_rvalid) state_nxt = RSP;
            RSP:   if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;
        busy          = 1'b0;
        case (state)
            WADDR: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                busy          = 1'b1;
            end
            WRESP: begin m_axi_bready  = 1'b1; busy = 1'b1; end
            RADDR: begin m_axi_arvalid = 1'b1; busy = 1'b1; end
            RDATA: begin m_axi_rready  = 1'b1; busy = 1'b1; end
            RSP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = data_q;
    assign m_axi_wstrb  = strb_q;
    assign rsp_data     = rdata_q;
    assign rsp_resp     = resp_q;
    assign rsp_flags    = {to_flag, mismatch_q};
    assign rsp_hs       = rsp_valid && rsp_ready;

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < STRB_W; i++) cmp_mask[8*i +: 8] = {8{strb_q[i]}};
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (pop) begin
                op_q    <= head_op;
                addr_q  <= head_addr;
                data_q  <= head_data;
                strb_q  <= head_strb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
            if (m_axi_bready && m_axi_bvalid) begin
                rdata_q    <= '0;
                resp_q     <= m_axi_bresp;
                mismatch_q <= 1'b0;
            end
            if (m_axi_rready && m_axi_rvalid) begin
                rdata_q    <= m_axi_rdata;
                resp_q     <= m_axi_rresp;
                mismatch_q <= (op_q == 2'b10) && |((m_axi_rdata ^ data_q) & cmp_mask);
            end
        end
    end

    // Terminal count of zero is never loaded as "expired", so TIMEOUT=0 never flags.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (pop) begin
            to_cnt  <= TO_W'(TIMEOUT);
            to_flag <= 1'b0;
        end else if (busy && to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
            if (to_cnt == TO_W'(1)) to_flag <= 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            err_count <= '0;
        end else if (rsp_hs && (resp_q != 2'b00 || mismatch_q || to_flag) &&
                     err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: behavioural AXI-Lite slave with configurable
// delays plus a memory/queue reference model of the expected responses.
module tb_axi_lite_cmd_master;
    localparam int TOUT = 8;

    logic        axi_aclk = 1'b0;
    logic        axi_areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp, rsp_flags;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic [31:0] m_axi_rdata = '0;
    logic [15:0] err_count;

    always #5 axi_aclk = ~axi_aclk;

    axi_lite_cmd_master #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .TIMEOUT(TOUT)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_flags(rsp_flags),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .err_count(err_count)
    );

    // Slave configuration and observation counters
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic [31:0] smem [int];
    int          n_aw = 0, n_w = 0, viol = 0;

    bit          aw_got, w_got, b_fire, ar_got, r_fire;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [15:0] aw_addr_q, ar_addr_q;
    logic [31:0] w_data_q, s_cur;
    logic [3:0]  w_strb_q;

    // Slave decisions are made on the falling edge; handshakes land on the next rising edge.
    always @(negedge axi_aclk) begin
        if (axi_areset) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (aw_got && m_axi_awvalid) viol++;
            if (w_got && m_axi_wvalid) viol++;
            if (!aw_got && aw_wait > 0 && !m_axi_awvalid) viol++;
            if (!w_got && w_wait > 0 && !m_axi_wvalid) viol++;

            if (b_fire) begin
                m_axi_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0;
            end else if (aw_got && w_got) begin
                if (!m_axi_bvalid) begin
                    if (b_wait >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = resp_cfg; end
                    else b_wait++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_fire = 1;
                    s_cur = smem.exists(int'(aw_addr_q)) ? smem[int'(aw_addr_q)] : 32'h0;
                    for (int i = 0; i < 4; i++) if (w_strb_q[i]) s_cur[8*i +: 8] = w_data_q[8*i +: 8];
                    smem[int'(aw_addr_q)] = s_cur;
                end
            end
            if (m_axi_awvalid && !aw_got) begin
                if (aw_wait >= aw_delay) begin
                    m_axi_awready = 1; aw_got = 1; aw_addr_q = m_axi_awaddr; n_aw++;
                end else begin m_axi_awready = 0; aw_wait++; end
            end else m_axi_awready = 0;
            if (m_axi_wvalid && !w_got) begin
                if (w_wait >= w_delay) begin
                    m_axi_wready = 1; w_got = 1; w_data_q = m_axi_wdata; w_strb_q = m_axi_wstrb; n_w++;
                end else begin m_axi_wready = 0; w_wait++; end
            end else m_axi_wready = 0;

            if (r_fire) begin
                m_axi_rvalid = 0; r_fire = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
            end else if (ar_got) begin
                if (!m_axi_rvalid) begin
                    if (r_wait >= r_delay) begin
                        m_axi_rvalid = 1; m_axi_rresp = resp_cfg;
                        m_axi_rdata = smem.exists(int'(ar_addr_q)) ? smem[int'(ar_addr_q)] : 32'h0;
                    end else r_wait++;
                end
                if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            end
            if (m_axi_arvalid && !ar_got) begin
                if (ar_wait >= ar_delay) begin m_axi_arready = 1; ar_got = 1; ar_addr_q = m_axi_araddr; end
                else begin m_axi_arready = 0; ar_wait++; end
            end else m_axi_arready = 0;
        end
    end

    // Reference model
    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic [1:0] flags; } exp_t;
    logic [31:0] mm [int];
    exp_t        expq [$];
    int          checks = 0, errors = 0, err_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        logic [31:0] cur;
        int          busy_cyc, n;
        bit          mis;
        cur = mm.exists(int'(addr)) ? mm[int'(addr)] : 32'h0;
        mis = 0;
        if (op == 2'b00) begin
            for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
            mm[int'(addr)] = cur;
            e.data = 32'h0;
            busy_cyc = ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay + 2;
        end else begin
            e.data = cur;
            busy_cyc = ar_delay + r_delay + 2;
            if (op == 2'b10)
                for (int i = 0; i < 4; i++) if (strb[i] && cur[8*i +: 8] != data[8*i +: 8]) mis = 1;
        end
        e.resp  = resp_cfg;
        e.flags = {(busy_cyc >= TOUT), mis};
        expq.push_back(e);
        @(negedge axi_aclk);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge axi_aclk); n++; end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge axi_aclk);
        #1 cmd_valid = 0;
    endtask

    task automatic collect(input int stall, output int lat);
        exp_t e;
        int   n;
        repeat (stall) @(negedge axi_aclk);
        @(negedge axi_aclk);
        rsp_ready = 1;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge axi_aclk); n++; end
        lat = n;
        check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        if (expq.size() == 0) begin
            check("rsp_unexpected", expq.size(), 32'd1);
            rsp_ready = 0;
            return;
        end
        e = expq.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
        check("rsp_flags", {30'd0, rsp_flags}, {30'd0, e.flags});
        if ((e.resp != 2'b00 || e.flags != 2'b00) && err_model < 65535) err_model++;
        @(posedge axi_aclk);
        #1 rsp_ready = 0;
        @(negedge axi_aclk);
        check("err_count", {16'd0, err_count}, err_model);
    endtask

    task automatic do_reset();
        @(negedge axi_aclk);
        axi_areset = 1;
        repeat (2) @(negedge axi_aclk);
        axi_areset = 0;
        expq.delete();
        err_model = 0;
    endtask

    initial begin
        int  lat, n, base_aw, base_w, cnt;
        bit  saw;
        // reset state
        repeat (3) @(negedge axi_aclk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("rst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        axi_areset = 0;
        @(negedge axi_aclk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // write then read with the reference slave
        push(2'b00, 16'h0010, 32'h12345678, 4'hF);
        collect(0, lat);
        check("write_latency", lat, 32'd3);
        push(2'b01, 16'h0010, 32'h0, 4'h0);
        collect(0, lat);
        check("read_latency", lat, 32'd3);

        // read-compare with partial and full mask
        do_reset();
        smem[32'h20] = 32'hFFABEECD;
        mm[32'h20]   = 32'hFFABEECD;
        push(2'b10, 16'h0020, 32'h00AB00CD, 4'b0101);
        collect(0, lat);
        push(2'b10, 16'h0020, 32'h00AB00CD, 4'b1111);
        collect(0, lat);
        check("cmp_err_count", {16'd0, err_count}, 32'd1);
        push(2'b10, 16'h0020, 32'h00AB00CD, 4'b0000);
        collect(0, lat);

        // AW/W handshake ordering
        base_aw = n_aw; base_w = n_w;
        aw_delay = 3; w_delay = 0;
        push(2'b00, 16'h0004, 32'hCAFEF00D, 4'b0011);
        collect(0, lat);
        aw_delay = 0; w_delay = 3;
        push(2'b00, 16'h0004, 32'hDEADBEEF, 4'b1100);
        collect(0, lat);
        w_delay = 0;
        check("aw_count", n_aw - base_aw, 32'd2);
        check("w_count", n_w - base_w, 32'd2);
        check("valid_drop_viol", viol, 32'd0);
        push(2'b01, 16'h0004, 32'h0, 4'h0);
        collect(0, lat);

        // reset in the middle of a write
        aw_delay = 10;
        push(2'b00, 16'h0100, 32'h55AA55AA, 4'hF);
        expq.delete();
        n = 0;
        while (!m_axi_awvalid && n < 20) begin @(negedge axi_aclk); n++; end
        check("awvalid_rise", {31'd0, m_axi_awvalid}, 32'd1);
        axi_areset = 1;
        @(negedge axi_aclk);
        check("rst_mid_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("rst_mid_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_mid_err_count", {16'd0, err_count}, 32'd0);
        axi_areset = 0;
        aw_delay = 0;
        err_model = 0;
        saw = 0;
        repeat (10) begin @(negedge axi_aclk); if (rsp_valid || m_axi_awvalid) saw = 1; end
        check("rst_mid_no_rsp", {31'd0, saw}, 32'd0);

        // FIFO full with response backpressure
        for (int i = 0; i < 5; i++)
            push(2'(i % 2), 16'(8 * i), $urandom, 4'($urandom_range(1, 15)));
        repeat (4) @(negedge axi_aclk);
        check("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
        check("fifo_full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) collect($urandom_range(0, 2), lat);

        // timeout: stalled B with SLVERR, then read boundary around TIMEOUT
        b_delay = 20; resp_cfg = 2'b10;
        push(2'b00, 16'h0008, 32'h01020304, 4'hF);
        collect(0, lat);
        b_delay = 0; resp_cfg = 2'b00;
        r_delay = 6;
        push(2'b01, 16'h0008, 32'h0, 4'h0);
        collect(0, lat);
        r_delay = 5;
        push(2'b01, 16'h0008, 32'h0, 4'h0);
        collect(0, lat);
        r_delay = 0;

        // randomized batches
        for (int b = 0; b < 25; b++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            resp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            cnt = $urandom_range(1, 3);
            for (int k = 0; k < cnt; k++)
                push(2'($urandom_range(0, 3)), 16'(4 * $urandom_range(0, 7)), $urandom,
                     4'($urandom_range(0, 15)));
            for (int k = 0; k < cnt; k++) collect($urandom_range(0, 2), lat);
        end
        check("final_viol", viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
